// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states, op-class helpers.
package alu_mc_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'h00,
    OP_SUB   = 5'h01,
    OP_AND   = 5'h02,
    OP_OR    = 5'h03,
    OP_XOR   = 5'h04,
    OP_SLL   = 5'h05,
    OP_SRL   = 5'h06,
    OP_NOR   = 5'h07,
    OP_SLT   = 5'h08,
    OP_SLE   = 5'h09,
    OP_SEQ   = 5'h0A,
    OP_SNE   = 5'h0B,
    OP_SGT   = 5'h0C,
    OP_SGE   = 5'h0D,
    OP_SRA   = 5'h0E,
    OP_MULLO = 5'h10,
    OP_MULHI = 5'h11,
    OP_DIVU  = 5'h12,
    OP_REMU  = 5'h13
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Ops that go through the iterative engine instead of the single-cycle mux.
  function automatic logic is_multi(input logic [4:0] op);
    return (op == OP_MULLO) || (op == OP_MULHI) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // Divide-class ops; the rest of the multi-cycle ops are multiplies.
  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // Ops whose answer is the upper half of the engine (MULHI product, REMU remainder).
  function automatic logic sel_hi_op(input logic [4:0] op);
    return (op == OP_MULHI) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative unsigned multiply / restoring divide engine sharing one 2*WIDTH register.
// MUL: shift-add, acc = {product_hi, product_lo}. DIV: acc = {remainder, quotient}.
// The first bit-step is applied on the start edge, so WIDTH steps finish on the
// WIDTH-1'th busy edge; lo/hi present the final step's value while done is high.
module alu_mc_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   opb_q;
  logic               div_q;
  logic               busy_q;
  logic [CW-1:0]      cnt_q;

  // One bit-step of either algorithm. Both start from acc = {0, a}.
  function automatic logic [2*WIDTH-1:0] step_fn(input logic [2*WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0]   opb,
                                                 input logic               div);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff  = trial - {1'b0, opb};
    if (!div) begin
      step_fn = {sum, acc[WIDTH-1:1]};
    end else if (trial >= {1'b0, opb}) begin
      // A zero divisor always "fits": quotient fills with ones, remainder ends as a.
      step_fn = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      step_fn = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  endfunction

  // Next value of the accumulator for the operation in flight.
  always_comb begin
    acc_step = step_fn(acc_q, opb_q, div_q);
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(WIDTH - 2));
  assign lo   = acc_step[WIDTH-1:0];
  assign hi   = acc_step[2*WIDTH-1:WIDTH];

  // Operand capture on start, then one step per edge until the last step is consumed.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opb_q  <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      acc_q  <= step_fn({{WIDTH{1'b0}}, a}, b, is_div);
      opb_q  <= b;
      div_q  <= is_div;
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle op mux inline, mul/div through alu_mc_muldiv,
// valid/ready on both sides with a registered result.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             illegal_q;
  logic             sel_hi_q;
  logic             md_start;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_res;
  logic [SHW-1:0]   shamt;

  assign shamt    = b[SHW-1:0];
  assign md_start = accept && is_multi(op);
  assign md_res   = sel_hi_q ? md_hi : md_lo;

  alu_mc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (is_div_op(op)),
    .a      (a),
    .b      (b),
    .busy   (md_busy),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  // Single-cycle op mux; undefined ops (including mul/div codes, unused here) give 0.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, a <  b};
      OP_SLE:  alu_res = {{(WIDTH-1){1'b0}}, a <= b};
      OP_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, a == b};
      OP_SNE:  alu_res = {{(WIDTH-1){1'b0}}, a != b};
      OP_SGT:  alu_res = {{(WIDTH-1){1'b0}}, a >  b};
      OP_SGE:  alu_res = {{(WIDTH-1){1'b0}}, a >= b};
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_MULLO, OP_MULHI, OP_DIVU, OP_REMU: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // Handshake outputs and next state.
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == S_IDLE) && !md_busy;
    out_valid = (state_q == S_DONE);
    accept    = in_valid && in_ready;
    case (state_q)
      S_IDLE:  if (accept) state_d = is_multi(op) ? S_ITER : S_DONE;
      S_ITER:  if (md_done) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Result registers: loaded on a single-cycle accept or on the engine's last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      sel_hi_q  <= 1'b0;
    end else if (accept) begin
      sel_hi_q <= sel_hi_op(op);
      if (!is_multi(op)) begin
        result_q  <= alu_res;
        zero_q    <= (alu_res == '0);
        illegal_q <= alu_ill;
      end
    end else if (state_q == S_ITER && md_done) begin
      result_q  <= md_res;
      zero_q    <= (md_res == '0);
      illegal_q <= 1'b0;
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32): hand-computed vectors, latency, back-pressure, async reset.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op at a negedge, measure edges to out_valid (accept edge = 1), check, consume.
  task automatic run_op(input string tag, input logic [4:0] o, input logic [WIDTH-1:0] va,
                        input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] exp_res,
                        input logic exp_ill, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    op = o;
    a = va;
    b = vb;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      // Scramble inputs after the accept edge; the DUT must ignore them.
      in_valid = 1'b0;
      op = 5'(OP_ADD);
      a = 32'h1234_5678;
      b = 32'h0000_0001;
    end while (!out_valid && lat < 200);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, zero, (exp_res == '0));
    check({tag, "_illegal"}, illegal, exp_ill);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_back_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    #12;
    check("reset_state", {in_ready, out_valid, zero, illegal}, 4'b1010);
    check("reset_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // out_ready high while idle must not produce anything.
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_out_ready", {out_valid, in_ready}, 2'b01);
    out_ready = 1'b0;

    // Single-cycle ops.
    run_op("add_wrap", 5'(OP_ADD), 32'hFFFF_FFFF, 32'h1,        32'h0,         1'b0, 1);
    run_op("sub",      5'(OP_SUB), 32'h5,         32'h7,        32'hFFFF_FFFE, 1'b0, 1);
    run_op("sra",      5'(OP_SRA), 32'h8000_0000, 32'h21,       32'hC000_0000, 1'b0, 1);
    run_op("sll",      5'(OP_SLL), 32'h1,         32'h23,       32'h8,         1'b0, 1);
    run_op("srl",      5'(OP_SRL), 32'h8000_0000, 32'h1F,       32'h1,         1'b0, 1);
    run_op("nor",      5'(OP_NOR), 32'hF0F0_0000, 32'h0000_0F0F, 32'h0F0F_F0F0, 1'b0, 1);
    run_op("slt_uns",  5'(OP_SLT), 32'h1,         32'hFFFF_FFFF, 32'h1,        1'b0, 1);
    run_op("sge_eq",   5'(OP_SGE), 32'h7,         32'h7,        32'h1,         1'b0, 1);
    run_op("sgt_no",   5'(OP_SGT), 32'h7,         32'h7,        32'h0,         1'b0, 1);
    run_op("seq",      5'(OP_SEQ), 32'hABCD,      32'hABCD,     32'h1,         1'b0, 1);
    run_op("sne",      5'(OP_SNE), 32'hABCD,      32'hABCD,     32'h0,         1'b0, 1);

    // Iterative ops, latency WIDTH.
    run_op("mullo", 5'(OP_MULLO), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32);
    run_op("mulhi", 5'(OP_MULHI), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32);
    run_op("mulhi_s", 5'(OP_MULHI), 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 1'b0, 32);
    run_op("divu",  5'(OP_DIVU),  32'd100, 32'd7, 32'd14,         1'b0, 32);
    run_op("remu",  5'(OP_REMU),  32'd100, 32'd7, 32'd2,          1'b0, 32);
    run_op("divu0", 5'(OP_DIVU),  32'd5,   32'd0, 32'hFFFF_FFFF,  1'b0, 32);
    run_op("remu0", 5'(OP_REMU),  32'd5,   32'd0, 32'd5,          1'b0, 32);

    // Back-pressure: 3+4 held in DONE for 10 cycles.
    @(negedge clk);
    in_valid = 1'b1;
    op = 5'(OP_ADD);
    a = 32'd3;
    b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    op = 5'(OP_SUB);
    a = 32'd9;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {out_valid, in_ready}, 2'b10);
      check("bp_result", result, 32'd7);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release", {out_valid, in_ready}, 2'b01);
    run_op("illegal_1f", 5'h1F, 32'h5, 32'h6, 32'h0, 1'b1, 1);
    run_op("illegal_0f", 5'h0F, 32'h5, 32'h6, 32'h0, 1'b1, 1);
    run_op("after_ill", 5'(OP_XOR), 32'hFF00, 32'h0FF0, 32'hF0F0, 1'b0, 1);

    // Async reset in the middle of a MULLO.
    @(negedge clk);
    in_valid = 1'b1;
    op = 5'(OP_MULLO);
    a = 32'd6;
    b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("iter_busy", {out_valid, in_ready}, 2'b00);
    rst_n = 1'b0;
    #1;
    check("rst_mid_state", {out_valid, in_ready, zero, illegal}, 4'b0110);
    check("rst_mid_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_result", {out_valid, in_ready}, 2'b01);
    run_op("post_rst_mul", 5'(OP_MULLO), 32'd6, 32'd7, 32'd42, 1'b0, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
